alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Packet-level controller between the UART byte streams (uart_rx / uart_tx) and the ALU datapath of the icebreaker top. It parses command packets and drives operands into the adder, or sequences them through the external multi-cycle multiplier and divider. It then serialises the result back out as little-endian bytes. It also provides resync on malformed packets and on inter-byte timeout.

Parameters:
TimeoutCycles, 1000000, idle clocks between accepted rx bytes inside a packet before abort/resync (~31 ms at 32.256 MHz)
MaxLen, 16'd1024, largest legal packet length in bytes; larger lengths are drained

Ports:
clk_i  in  1  system clock (32.256 MHz PLL out)
rst_i  in  1  synchronous active-high reset
rx_tdata_i  in  8  byte from uart_rx
rx_tvalid_i  in  1  rx byte valid
rx_tready_o  out  1  byte accepted when valid&&ready
tx_tdata_o  out  8  byte to uart_tx
tx_tvalid_o  out  1  tx byte valid
tx_tready_i  in  1  uart_tx ready
mul_a_o, mul_b_o  out  32 each  multiplier operands
mul_valid_o  out  1  multiplier start request
mul_ready_i  in  1  multiplier accepts request
mul_done_i  in  1  1-cycle pulse, mul_p_i valid
mul_p_i  in  32  low 32 bits of product
div_a_o, div_b_o  out  32 each  signed dividend/divisor
div_valid_o  out  1  divider start request
div_ready_i  in  1  divider accepts request
div_done_i  in  1  1-cycle pulse, div_q_i/div_r_i valid
div_q_i, div_r_i  in  32 each  quotient, remainder
busy_o  out  1  high in any state except HDR
err_o  out  1  1-cycle pulse on drop (bad opcode/length/timeout)

Behaviour:
- Packet: byte0 opcode (0xAD add, 0x63 mul, 0x5B div), byte1 reserved (ignored), bytes2-3 total length LSB first (header included), then (len-4)/4 operands, 32-bit little-endian.
- Validity: len%4==0, 8<=len<=MaxLen; div additionally requires len==12. An unknown opcode or illegal length gives DRAIN, which consumes len-4 further bytes (0 if len<4), emits an err_o pulse on entry, sends no response, and returns to HDR.
- States: HDR (byte counter 0-3) -> OPND (collect 4 bytes) -> EXEC -> next OPND or RESP -> HDR; DRAIN; TIMEOUT handled from any receiving state.
- rx_tready_o=1 only in HDR, OPND and DRAIN; 0 in EXEC and RESP.
- Add: acc reset to 0 at header; per operand acc<=acc+op (mod 2^32); EXEC takes 1 cycle.
- Mul: first operand loads acc (1 cycle). Each later operand raises mul_valid_o with a=acc, b=op, held until mul_ready_i. acc<=mul_p_i on mul_done_i.
- Div: first operand latched as dividend. Second operand raises div_valid_o with a=dividend, b=op, held until div_ready_i. Wait for div_done_i. Signed semantics and divide-by-zero results are owned by the divider.
- RESP: add/mul send 4 bytes of acc, LSB first. Div sends q[7:0]..q[31:24] then r[7:0]..r[31:24] (8 bytes). tx_tvalid_o rises the cycle after entering RESP. tx_tdata_o is stable while valid&&!ready. Advance only on valid&&ready. Return to HDR the cycle after the last handshake.
- Timeout: counter clears on every accepted rx byte. It counts while in HDR with byte counter!=0, in OPND, or in DRAIN. On reaching TimeoutCycles: err_o pulse, discard partial packet, go to HDR. No timeout in EXEC or RESP.
- Reset (any time, including mid-packet or mid-response): state HDR, counters 0, acc 0. All outputs 0 except rx_tready_o=1. An outstanding mul/div request is abandoned and later done pulses are ignored while not in EXEC.
- An rx byte is never accepted in the same cycle as a tx handshake, because the states are exclusive.

Test Plan:
- Add: AD 00 10 00 + ops 1, 2, 0xFFFFFFFF -> tx 02 00 00 00; busy_o low after last byte.
- Mul wrap: 63 00 0C 00 + 0x00010000, 0x00010001 -> tx 00 00 01 00, exactly one mul_valid_o handshake.
- Div: 5B 00 0C 00 + 100, 7 -> tx 0E 00 00 00 02 00 00 00; with tx_tready_i toggling every other cycle, bytes unchanged and in order.
- Bad opcode 0x11 len 12 -> err_o pulse, 8 bytes drained, no tx. Next add packet 5+6 -> 0B 00 00 00.
- Div with len 16 -> drained, err_o, no div_valid_o. Length 6 -> err_o, 2 bytes drained.
- Timeout: header + 2 operand bytes, then idle TimeoutCycles -> err_o, state HDR. Assert rst_i mid-operand -> all outputs at reset values, next packet processed correctly.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Packet controller between the UART byte streams and the ALU datapath: parses
// add/mul/div command packets, sequences the external units, returns LE results.
module alu_cmd_sequencer #(
  parameter int unsigned TimeoutCycles = 1000000,
  parameter logic [15:0] MaxLen        = 16'd1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_valid_o,
  input  logic        mul_ready_i,
  input  logic        mul_done_i,
  input  logic [31:0] mul_p_i,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_valid_o,
  input  logic        div_ready_i,
  input  logic        div_done_i,
  input  logic [31:0] div_q_i,
  input  logic [31:0] div_r_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [7:0] OpAdd = 8'hAD;
  localparam logic [7:0] OpMul = 8'h63;
  localparam logic [7:0] OpDiv = 8'h5B;
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] ToutLast = TW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {HDR, OPND, EXEC, RESP, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [1:0]    hdr_cnt_q, byte_cnt_q;
  logic [7:0]    opcode_q, len_lo_q;
  logic [15:0]   ops_left_q, drain_left_q;
  logic          first_q, req_pend_q;
  logic [31:0]   op_q, acc_q, dvd_q, quo_q, rem_q;
  logic [2:0]    resp_idx_q;
  logic          tx_valid_q, err_q;
  logic [7:0]    tx_data_q;
  logic [TW-1:0] tout_q;

  logic        rx_fire, tx_fire, is_add, is_mul, is_div;
  logic        hdr_ok, tout_active, tout_hit, exec_done, resp_last;
  logic [15:0] hdr_len, drain_len;
  logic [7:0]  resp_cur, resp_nxt;

  function automatic logic [7:0] pick_byte(input logic [2:0] idx, input logic div,
                                           input logic [31:0] a, input logic [31:0] q,
                                           input logic [31:0] r);
    logic [31:0] w;
    w = div ? (idx[2] ? r : q) : a;
    return w[{idx[1:0], 3'b000} +: 8];
  endfunction

  assign rx_tready_o = (state_q == HDR) || (state_q == OPND) || (state_q == DRAIN);
  assign rx_fire     = rx_tvalid_i && rx_tready_o;
  assign tx_fire     = tx_valid_q && tx_tready_i;
  assign is_add      = (opcode_q == OpAdd);
  assign is_mul      = (opcode_q == OpMul);
  assign is_div      = (opcode_q == OpDiv);

  // Length arrives LSB first; the high byte is the live rx byte.
  assign hdr_len   = {rx_tdata_i, len_lo_q};
  assign drain_len = (hdr_len < 16'd4) ? 16'd0 : hdr_len - 16'd4;
  assign hdr_ok    = (is_add || is_mul || is_div) && (hdr_len[1:0] == 2'b00) &&
                     (hdr_len >= 16'd8) && (hdr_len <= MaxLen) &&
                     (!is_div || hdr_len == 16'd12);

  assign tout_active = ((state_q == HDR) && (hdr_cnt_q != 2'd0)) ||
                       (state_q == OPND) || (state_q == DRAIN);
  assign tout_hit    = tout_active && !rx_fire && (tout_q == ToutLast);

  assign resp_last = (resp_idx_q == (is_div ? 3'd7 : 3'd3));
  assign resp_cur  = pick_byte(resp_idx_q, is_div, acc_q, quo_q, rem_q);
  assign resp_nxt  = pick_byte(resp_idx_q + 3'd1, is_div, acc_q, quo_q, rem_q);

  assign mul_valid_o = (state_q == EXEC) && is_mul && req_pend_q;
  assign div_valid_o = (state_q == EXEC) && is_div && req_pend_q;
  assign mul_a_o     = acc_q;
  assign mul_b_o     = op_q;
  assign div_a_o     = dvd_q;
  assign div_b_o     = op_q;
  assign tx_tvalid_o = tx_valid_q;
  assign tx_tdata_o  = tx_data_q;
  assign busy_o      = (state_q != HDR);
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= HDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    exec_done = 1'b0;
    case (state_q)
      HDR: begin
        if (rx_fire && hdr_cnt_q == 2'd3) begin
          if (hdr_ok)                  state_d = OPND;
          else if (drain_len == 16'd0) state_d = HDR;
          else                         state_d = DRAIN;
        end
      end
      OPND: if (rx_fire && byte_cnt_q == 2'd3) state_d = EXEC;
      EXEC: begin
        // A done pulse that lands together with the accepting handshake still counts.
        if (is_add || first_q) exec_done = 1'b1;
        else if (is_mul)       exec_done = mul_done_i && (!req_pend_q || mul_ready_i);
        else                   exec_done = div_done_i && (!req_pend_q || div_ready_i);
        if (exec_done) state_d = (ops_left_q == 16'd1) ? RESP : OPND;
      end
      RESP:  if (tx_fire && resp_last) state_d = HDR;
      DRAIN: if (rx_fire && drain_left_q == 16'd1) state_d = HDR;
      default: state_d = HDR;
    endcase
    if (tout_hit) state_d = HDR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      opcode_q     <= '0;
      len_lo_q     <= '0;
      ops_left_q   <= '0;
      drain_left_q <= '0;
      first_q      <= 1'b0;
      req_pend_q   <= 1'b0;
      op_q         <= '0;
      acc_q        <= '0;
      dvd_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      resp_idx_q   <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      err_q        <= 1'b0;
      tout_q       <= '0;
    end else begin
      err_q <= 1'b0;
      if (rx_fire || !tout_active) tout_q <= '0;
      else                         tout_q <= tout_q + TW'(1);

      case (state_q)
        HDR: begin
          if (rx_fire) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd0) opcode_q <= rx_tdata_i;
            if (hdr_cnt_q == 2'd2) len_lo_q <= rx_tdata_i;
            if (hdr_cnt_q == 2'd3) begin
              if (hdr_ok) begin
                ops_left_q <= {2'b00, hdr_len[15:2]} - 16'd1;
                acc_q      <= '0;
                first_q    <= 1'b1;
                byte_cnt_q <= '0;
              end else begin
                err_q        <= 1'b1;
                drain_left_q <= drain_len;
              end
            end
          end
        end
        OPND: begin
          if (rx_fire) begin
            op_q       <= {rx_tdata_i, op_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) req_pend_q <= !first_q && (is_mul || is_div);
          end
        end
        EXEC: begin
          if ((mul_valid_o && mul_ready_i) || (div_valid_o && div_ready_i)) req_pend_q <= 1'b0;
          if (exec_done) begin
            first_q    <= 1'b0;
            req_pend_q <= 1'b0;
            ops_left_q <= ops_left_q - 16'd1;
            resp_idx_q <= '0;
            if (is_add)       acc_q <= acc_q + op_q;
            else if (is_mul)  acc_q <= first_q ? op_q : mul_p_i;
            else if (first_q) dvd_q <= op_q;
            else begin
              quo_q <= div_q_i;
              rem_q <= div_r_i;
            end
          end
        end
        RESP: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= resp_cur;
          end else if (tx_fire) begin
            if (resp_last) tx_valid_q <= 1'b0;
            else begin
              resp_idx_q <= resp_idx_q + 3'd1;
              tx_data_q  <= resp_nxt;
            end
          end
        end
        DRAIN: if (rx_fire) drain_left_q <= drain_left_q - 16'd1;
        default: ;
      endcase

      if (tout_hit) begin
        err_q      <= 1'b1;
        tout_q     <= '0;
        hdr_cnt_q  <= '0;
        byte_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with behavioural
// multiplier/divider mocks and a packet-level reference model.
module tb_alu_cmd_sequencer;

  localparam int unsigned TOUT = 300;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_tdata_i = '0;
  logic        rx_tvalid_i = 1'b0;
  logic        rx_tready_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i = 1'b0;
  logic [31:0] mul_a_o, mul_b_o, div_a_o, div_b_o;
  logic        mul_valid_o, div_valid_o;
  logic        mul_ready_i = 1'b0, mul_done_i = 1'b0;
  logic        div_ready_i = 1'b0, div_done_i = 1'b0;
  logic [31:0] mul_p_i = '0, div_q_i = '0, div_r_i = '0;
  logic        busy_o, err_o;

  alu_cmd_sequencer #(.TimeoutCycles(TOUT), .MaxLen(16'd1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
    .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_valid_o(mul_valid_o),
    .mul_ready_i(mul_ready_i), .mul_done_i(mul_done_i), .mul_p_i(mul_p_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_valid_o(div_valid_o),
    .div_ready_i(div_ready_i), .div_done_i(div_done_i),
    .div_q_i(div_q_i), .div_r_i(div_r_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int errCount = 0, mulHs = 0, divHs = 0;
  int txMode = 0;
  int mulWait = 0, divWait = 0;
  logic [31:0] mulRes = '0;
  logic [63:0] divRes = '0;
  logic stall = 1'b0, tog = 1'b0;
  logic [7:0] held = '0;
  byte unsigned txQ[$];
  byte unsigned expQ[$];
  byte unsigned stimPl[$];
  int expErr, expMulHs, expDivHs;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behaviour of the external divider: signed, with fixed results for x/0 and overflow.
  function automatic logic [63:0] divRef(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  // Monitor + mocks: tx sink, err counter, multiplier and divider with random latency.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (err_o) errCount++;
      if (stall && !rst_i)
        checkOutput("txHold", {23'd0, tx_tvalid_o, tx_tdata_o}, {23'd0, 1'b1, held});
      tog = ~tog;
      case (txMode)
        0: tx_tready_i = 1'b1;
        1: tx_tready_i = ($urandom_range(0, 1) == 1);
        default: tx_tready_i = tog;
      endcase
      stall = tx_tvalid_o && !tx_tready_i;
      held  = tx_tdata_o;
      if (tx_tvalid_o && tx_tready_i) txQ.push_back(tx_tdata_o);

      mul_done_i = 1'b0;
      mul_p_i    = $urandom;
      if (mulWait > 0) begin
        mulWait--;
        if (mulWait == 0) begin mul_done_i = 1'b1; mul_p_i = mulRes; end
      end
      mul_ready_i = ($urandom_range(0, 2) != 0);
      if (mul_valid_o && mul_ready_i) begin
        mulHs++;
        mulRes  = mul_a_o * mul_b_o;
        mulWait = $urandom_range(1, 5);
      end

      div_done_i = 1'b0;
      div_q_i    = $urandom;
      div_r_i    = $urandom;
      if (divWait > 0) begin
        divWait--;
        if (divWait == 0) begin div_done_i = 1'b1; div_q_i = divRes[31:0]; div_r_i = divRes[63:32]; end
      end
      div_ready_i = ($urandom_range(0, 2) != 0);
      if (div_valid_o && div_ready_i) begin
        divHs++;
        divRes  = divRef(div_a_o, div_b_o);
        divWait = $urandom_range(1, 6);
      end
      if (rst_i) begin mulWait = 0; divWait = 0; stall = 1'b0; end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) expQ.push_back(w[8*b +: 8]);
  endtask

  task automatic addWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stimPl.push_back(w[8*b +: 8]);
  endtask

  // Packet-level reference: validity rules, then plain arithmetic on the operand list.
  task automatic refModel(input byte unsigned opc, input int len, input byte unsigned pl[$]);
    logic [31:0] ops[$];
    logic [31:0] acc;
    logic [63:0] qr;
    bit ok;
    expQ.delete();
    expErr = 0; expMulHs = 0; expDivHs = 0;
    ok = (opc == 8'hAD || opc == 8'h63 || opc == 8'h5B) && (len % 4 == 0) &&
         (len >= 8) && (len <= 1024) && (opc != 8'h5B || len == 12);
    if (!ok) begin expErr = 1; return; end
    for (int i = 0; i + 3 < pl.size(); i += 4) ops.push_back({pl[i+3], pl[i+2], pl[i+1], pl[i]});
    if (opc == 8'hAD) begin
      acc = 32'd0;
      foreach (ops[i]) acc = acc + ops[i];
      pushWord(acc);
    end else if (opc == 8'h63) begin
      acc = ops[0];
      for (int i = 1; i < ops.size(); i++) acc = acc * ops[i];
      expMulHs = ops.size() - 1;
      pushWord(acc);
    end else begin
      qr = divRef(ops[0], ops[1]);
      expDivHs = 1;
      pushWord(qr[31:0]);
      pushWord(qr[63:32]);
    end
  endtask

  task automatic sendByte(input byte unsigned b);
    int n = 0;
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    while (!rx_tready_o && n < 5000) begin @(posedge clk_i); #1; n++; end
    if (!rx_tready_o) checkOutput("rxStall", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    rx_tvalid_i = 1'b0;
  endtask

  task automatic applyStimulus(input byte unsigned pkt[$]);
    foreach (pkt[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      sendByte(pkt[i]);
    end
  endtask

  task automatic runPacket(input string name, input byte unsigned opc, input logic [15:0] len);
    byte unsigned pkt[$];
    int e0, m0, d0, k, n;
    pkt = {opc, 8'($urandom), len[7:0], len[15:8]};
    foreach (stimPl[i]) pkt.push_back(stimPl[i]);
    refModel(opc, int'(len), stimPl);
    e0 = errCount; m0 = mulHs; d0 = divHs;
    txQ.delete();
    applyStimulus(pkt);
    n = expQ.size();
    k = 0;
    while (txQ.size() < n && k < 5000) begin @(posedge clk_i); #1; k++; end
    repeat (2) begin @(posedge clk_i); #1; end
    checkOutput({name, "_busy"}, busy_o, 1'b0);
    repeat (3) begin @(posedge clk_i); #1; end
    checkOutput({name, "_txCount"}, txQ.size(), n);
    for (int i = 0; i < n && i < txQ.size(); i++)
      checkOutput($sformatf("%s_b%0d", name, i), txQ[i], expQ[i]);
    checkOutput({name, "_err"}, errCount - e0, expErr);
    checkOutput({name, "_mulHs"}, mulHs - m0, expMulHs);
    checkOutput({name, "_divHs"}, divHs - d0, expDivHs);
    stimPl.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rxRdy"}, rx_tready_o, 1'b1);
    checkOutput({tag, "_txValid"}, tx_tvalid_o, 1'b0);
    checkOutput({tag, "_txData"}, tx_tdata_o, 8'd0);
    checkOutput({tag, "_busy"}, busy_o, 1'b0);
    checkOutput({tag, "_err"}, err_o, 1'b0);
    checkOutput({tag, "_mulValid"}, mul_valid_o, 1'b0);
    checkOutput({tag, "_divValid"}, div_valid_o, 1'b0);
    checkOutput({tag, "_mulA"}, mul_a_o, 32'd0);
    checkOutput({tag, "_divA"}, div_a_o, 32'd0);
  endtask

  initial begin
    int e0, kind, nops;
    logic [15:0] len;
    byte unsigned opc;
    int badLens[8] = '{0, 2, 4, 5, 6, 10, 13, 17};

    rst_i = 1'b1;
    repeat (3) begin @(posedge clk_i); #1; end
    checkResetState("rst");
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    txMode = 0;
    addWord(32'd1); addWord(32'd2); addWord(32'hFFFF_FFFF);
    runPacket("add3", 8'hAD, 16'd16);

    addWord(32'h0001_0000); addWord(32'h0001_0001);
    runPacket("mulWrap", 8'h63, 16'd12);

    txMode = 2;
    addWord(32'd100); addWord(32'd7);
    runPacket("divTog", 8'h5B, 16'd12);
    txMode = 0;

    for (int i = 0; i < 8; i++) stimPl.push_back(8'($urandom));
    runPacket("badOpc", 8'h11, 16'd12);
    addWord(32'd5); addWord(32'd6);
    runPacket("addAfterBad", 8'hAD, 16'd12);

    for (int i = 0; i < 12; i++) stimPl.push_back(8'($urandom));
    runPacket("divLen16", 8'h5B, 16'd16);

    stimPl.push_back(8'hAA); stimPl.push_back(8'h55);
    runPacket("len6", 8'hAD, 16'd6);
    addWord(32'hFFFF_FFFF); addWord(32'd2);
    runPacket("addAfterLen6", 8'hAD, 16'd12);

    for (int i = 0; i < 1024; i++) stimPl.push_back(8'($urandom));
    runPacket("overMax", 8'hAD, 16'd1028);

    // Stall mid-operand until the inter-byte timeout fires.
    e0 = errCount;
    sendByte(8'hAD); sendByte(8'h00); sendByte(8'h0C); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22);
    repeat (TOUT - 20) begin @(posedge clk_i); #1; end
    checkOutput("toBusyBefore", busy_o, 1'b1);
    checkOutput("toErrBefore", errCount - e0, 0);
    repeat (40) begin @(posedge clk_i); #1; end
    checkOutput("toErr", errCount - e0, 1);
    checkOutput("toBusyAfter", busy_o, 1'b0);
    addWord(32'd40); addWord(32'd2);
    runPacket("addAfterTo", 8'hAD, 16'd12);

    sendByte(8'h63); sendByte(8'h00); sendByte(8'h0C); sendByte(8'h00); sendByte(8'h01);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkResetState("midRst");
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    addWord(32'd3); addWord(32'd9);
    runPacket("mulAfterRst", 8'h63, 16'd12);

    for (int p = 0; p < 40; p++) begin
      txMode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind <= 5 || kind == 6 || kind == 7) begin
        opc  = (kind <= 2) ? 8'hAD : (kind <= 5) ? 8'h63 : 8'h5B;
        nops = (opc == 8'h5B) ? 2 : $urandom_range(1, 6);
        len  = 16'(4 + 4 * nops);
        for (int i = 0; i < nops; i++) begin
          if ($urandom_range(0, 5) == 0) addWord(32'd0);
          else if ($urandom_range(0, 1) == 0) addWord($urandom_range(0, 300));
          else addWord($urandom);
        end
      end else begin
        if (kind == 8) begin
          opc = 8'($urandom);
          while (opc == 8'hAD || opc == 8'h63 || opc == 8'h5B) opc = 8'($urandom);
          len = 16'(4 * $urandom_range(0, 5));
        end else begin
          opc = ($urandom_range(0, 1) == 0) ? 8'hAD : 8'h5B;
          len = 16'(badLens[$urandom_range(0, 7)]);
          if (opc == 8'h5B && $urandom_range(0, 1) == 0) len = ($urandom_range(0, 1) == 0) ? 16'd8 : 16'd16;
        end
        for (int i = 4; i < int'(len); i++) stimPl.push_back(8'($urandom));
      end
      runPacket($sformatf("rnd%0d", p), opc, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
